// File: rtl/arb_pkg.sv
// Shared types for the BRAM port arbiter: controller state and response-owner tags.
package arb_pkg;

    typedef enum logic {
        ARB_LOAD,
        ARB_RUN
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_LS
    } arb_tag_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_resp_pipe.sv
// Owner-tag shift register matching the BRAM read latency; flush_in turns IF tags into TAG_NONE,
// including the tag emerging at the output this cycle.
module arb_resp_pipe
    import arb_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     flush_in,
    input  arb_tag_t tag_in,
    output arb_tag_t tag_out
);

    arb_tag_t r_stage [RD_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // The tag entering this cycle belongs to a grant made alongside the flush and survives it.
                always_ff @(posedge clk_in or negedge rst_in) begin
                    if (!rst_in) begin
                        r_stage[0] <= TAG_NONE;
                    end else begin
                        r_stage[0] <= tag_in;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk_in or negedge rst_in) begin
                    if (!rst_in) begin
                        r_stage[gi] <= TAG_NONE;
                    end else if (flush_in && (r_stage[gi-1] == TAG_IF)) begin
                        r_stage[gi] <= TAG_NONE;
                    end else begin
                        r_stage[gi] <= r_stage[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign tag_out = (flush_in && (r_stage[RD_LATENCY-1] == TAG_IF)) ? TAG_NONE
                                                                      : r_stage[RD_LATENCY-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between boot loader, instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin IF/LS arbitration instead of LS priority with MAX_WAIT.
module bram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2,
    parameter int LOAD_WORDS = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              boot_valid_in,
    input  logic [DATA_W-1:0] boot_data_in,
    output logic              boot_ready_out,
    input  logic              if_valid_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_ready_out,
    output logic              if_rvalid_out,
    output logic [DATA_W-1:0] if_rdata_out,
    input  logic              ls_valid_in,
    input  logic              ls_we_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [DATA_W-1:0] ls_wdata_in,
    output logic              ls_ready_out,
    output logic              ls_rvalid_out,
    output logic [DATA_W-1:0] ls_rdata_out,
    input  logic              flush_in,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_din_out,
    output logic              ram_we_out,
    input  logic [DATA_W-1:0] ram_dout_in,
    output logic              run_out
);

    localparam int LCNT_W = cnt_width(LOAD_WORDS);
    localparam logic [LCNT_W-1:0] LAST_IDX = LCNT_W'((LOAD_WORDS == 0) ? 0 : LOAD_WORDS - 1);

    arb_state_t        r_state;
    logic              r_run;
    logic [LCNT_W-1:0] r_load_cnt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_din_hold;

    logic              w_in_load;
    logic              w_in_run;
    logic              w_boot_grant;
    logic              w_if_req;
    logic              w_ls_req;
    logic              w_if_wins;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_any_grant;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_din_sel;
    arb_tag_t          w_tag_push;
    arb_tag_t          w_tag_out;

    // Qualifying with rst_in keeps every handshake output at 0 while reset is held.
    assign w_in_load = rst_in && (r_state == ARB_LOAD) && (LOAD_WORDS != 0);
    assign w_in_run  = rst_in && (r_state == ARB_RUN);

    assign w_boot_grant = w_in_load && boot_valid_in;
    assign w_if_req     = w_in_run && if_valid_in;
    assign w_ls_req     = w_in_run && ls_valid_in;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_if;

    assign w_if_wins = w_if_req && (!w_ls_req || !r_last_if);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_last_if <= 1'b1;
        end else if (w_grant_if) begin
            r_last_if <= 1'b1;
        end else if (w_grant_ls) begin
            r_last_if <= 1'b0;
        end
    end
`else
    localparam int WAIT_W = cnt_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait;

    assign w_if_wins = w_if_req && (!w_ls_req || (r_wait == WAIT_MAX));

    // Counts refused IF cycles; it cannot pass WAIT_MAX because IF wins at that value.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wait <= '0;
        end else if (w_grant_if) begin
            r_wait <= '0;
        end else if (w_if_req && (r_wait != WAIT_MAX)) begin
            r_wait <= r_wait + 1'b1;
        end
    end
`endif

    assign w_grant_if  = w_if_wins;
    assign w_grant_ls  = w_ls_req && !w_if_wins;
    assign w_any_grant = w_boot_grant || w_grant_if || w_grant_ls;

    always_comb begin
        w_addr_sel = r_addr_hold;
        w_din_sel  = r_din_hold;
        if (w_boot_grant) begin
            w_addr_sel = ADDR_W'(r_load_cnt);
            w_din_sel  = boot_data_in;
        end else if (w_grant_if) begin
            w_addr_sel = if_addr_in;
        end else if (w_grant_ls) begin
            w_addr_sel = ls_addr_in;
            w_din_sel  = ls_wdata_in;
        end
    end

    always_comb begin
        w_tag_push = TAG_NONE;
        if (w_grant_if) begin
            w_tag_push = TAG_IF;
        end else if (w_grant_ls && !ls_we_in) begin
            w_tag_push = TAG_LS;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= ARB_LOAD;
            r_run      <= 1'b0;
            r_load_cnt <= '0;
        end else begin
            case (r_state)
                ARB_LOAD: begin
                    if (LOAD_WORDS == 0) begin
                        r_state <= ARB_RUN;
                        r_run   <= 1'b1;
                    end else if (w_boot_grant) begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                        if (r_load_cnt == LAST_IDX) begin
                            r_state <= ARB_RUN;
                            r_run   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_RUN;
                    r_run   <= 1'b1;
                end
            endcase
        end
    end

    // Idle cycles replay the last address so the BRAM port stays quiet.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_addr_hold <= '0;
            r_din_hold  <= '0;
        end else if (w_any_grant) begin
            r_addr_hold <= w_addr_sel;
            r_din_hold  <= w_din_sel;
        end
    end

    arb_resp_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_resp_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .flush_in(flush_in),
        .tag_in  (w_tag_push),
        .tag_out (w_tag_out)
    );

    assign boot_ready_out = w_in_load;
    assign if_ready_out   = w_grant_if;
    assign ls_ready_out   = w_grant_ls;
    assign ram_addr_out   = w_addr_sel;
    assign ram_din_out    = w_din_sel;
    assign ram_we_out     = w_boot_grant || (w_grant_ls && ls_we_in);
    assign run_out        = r_run;

    assign if_rvalid_out  = (w_tag_out == TAG_IF);
    assign ls_rvalid_out  = (w_tag_out == TAG_LS);
    assign if_rdata_out   = if_rvalid_out ? ram_dout_in : '0;
    assign ls_rdata_out   = ls_rvalid_out ? ram_dout_in : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-first, two-cycle BRAM model.
module tb_bram_port_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        boot_valid_in;
    logic [31:0] boot_data_in;
    logic        boot_ready_out;
    logic        if_valid_in;
    logic [11:0] if_addr_in;
    logic        if_ready_out;
    logic        if_rvalid_out;
    logic [31:0] if_rdata_out;
    logic        ls_valid_in;
    logic        ls_we_in;
    logic [11:0] ls_addr_in;
    logic [31:0] ls_wdata_in;
    logic        ls_ready_out;
    logic        ls_rvalid_out;
    logic [31:0] ls_rdata_out;
    logic        flush_in;
    logic [11:0] ram_addr_out;
    logic [31:0] ram_din_out;
    logic        ram_we_out;
    logic [31:0] ram_dout_in;
    logic        run_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    bram_port_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .boot_valid_in (boot_valid_in),
        .boot_data_in  (boot_data_in),
        .boot_ready_out(boot_ready_out),
        .if_valid_in   (if_valid_in),
        .if_addr_in    (if_addr_in),
        .if_ready_out  (if_ready_out),
        .if_rvalid_out (if_rvalid_out),
        .if_rdata_out  (if_rdata_out),
        .ls_valid_in   (ls_valid_in),
        .ls_we_in      (ls_we_in),
        .ls_addr_in    (ls_addr_in),
        .ls_wdata_in   (ls_wdata_in),
        .ls_ready_out  (ls_ready_out),
        .ls_rvalid_out (ls_rvalid_out),
        .ls_rdata_out  (ls_rdata_out),
        .flush_in      (flush_in),
        .ram_addr_out  (ram_addr_out),
        .ram_din_out   (ram_din_out),
        .ram_we_out    (ram_we_out),
        .ram_dout_in   (ram_dout_in),
        .run_out       (run_out)
    );

    // Read-first single-port BRAM, address to douta in two cycles.
    logic [31:0] mem [4096];
    logic [31:0] dout_p1;
    logic [31:0] dout_p2;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        dout_p1 = '0;
        dout_p2 = '0;
    end

    always @(posedge clk_in) begin
        if (ram_we_out) mem[ram_addr_out] <= ram_din_out;
        dout_p1 <= mem[ram_addr_out];
        dout_p2 <= dout_p1;
    end

    assign ram_dout_in = dout_p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_v;
        logic [11:0] if_a;
        logic        ls_v;
        logic        ls_we;
        logic [11:0] ls_a;
        logic [31:0] ls_wd;
        logic        flush;
        logic        e_if_rdy;
        logic        e_ls_rdy;
        logic        e_we;
        logic [11:0] e_addr;
        logic        e_if_rv;
        logic [31:0] e_if_rd;
        logic        e_ls_rv;
        logic [31:0] e_ls_rd;
    } vec_t;

    function automatic vec_t mk(input int ifv, input int ifa, input int lsv, input int lswe,
                                input int lsa, input int lswd, input int fl, input int eir,
                                input int elr, input int ewe, input int ea, input int eirv,
                                input int eird, input int elrv, input int elrd);
        vec_t v;
        v.if_v     = 1'(ifv);
        v.if_a     = 12'(ifa);
        v.ls_v     = 1'(lsv);
        v.ls_we    = 1'(lswe);
        v.ls_a     = 12'(lsa);
        v.ls_wd    = 32'(lswd);
        v.flush    = 1'(fl);
        v.e_if_rdy = 1'(eir);
        v.e_ls_rdy = 1'(elr);
        v.e_we     = 1'(ewe);
        v.e_addr   = 12'(ea);
        v.e_if_rv  = 1'(eirv);
        v.e_if_rd  = 32'(eird);
        v.e_ls_rv  = 1'(elrv);
        v.e_ls_rd  = 32'(elrd);
        return v;
    endfunction

    localparam int NV = 21;
    vec_t vec [NV];

    task automatic idle_inputs();
        boot_valid_in = 1'b0;
        boot_data_in  = '0;
        if_valid_in   = 1'b0;
        if_addr_in    = '0;
        ls_valid_in   = 1'b0;
        ls_we_in      = 1'b0;
        ls_addr_in    = '0;
        ls_wdata_in   = '0;
        flush_in      = 1'b0;
    endtask

    initial begin
        //      ifv ifa lsv we lsa  wd    fl  eir elr ewe ea  eirv eird   elrv elrd
        vec[0]  = mk(1, 3, 0, 0, 0, 0,    0,  1, 0, 0, 3,  0, 0,     0, 0);     // IF read addr 3
        vec[1]  = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 3,  0, 0,     0, 0);
        vec[2]  = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 3,  1, 'hA3,  0, 0);
        vec[3]  = mk(0, 0, 1, 1, 7, 'h55, 0,  0, 1, 1, 7,  0, 0,     0, 0);     // store 0x55 @7
        vec[4]  = mk(0, 0, 1, 0, 7, 0,    0,  0, 1, 0, 7,  0, 0,     0, 0);     // load @7
        vec[5]  = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 7,  0, 0,     0, 0);
        vec[6]  = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 7,  0, 0,     1, 'h55);
        vec[7]  = mk(1, 1, 0, 0, 0, 0,    0,  1, 0, 0, 1,  0, 0,     0, 0);     // IF read, flushed next
        vec[8]  = mk(0, 0, 1, 0, 2, 0,    1,  0, 1, 0, 2,  0, 0,     0, 0);     // flush + LS load @2
        vec[9]  = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 2,  0, 0,     0, 0);
        vec[10] = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 2,  0, 0,     1, 'hA2);
        vec[11] = mk(1, 0, 0, 0, 0, 0,    1,  1, 0, 0, 0,  0, 0,     0, 0);     // IF granted with flush
        vec[12] = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 0,  0, 0,     0, 0);
        vec[13] = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 0,  1, 'hA0,  0, 0);
        vec[14] = mk(1, 4, 0, 0, 0, 0,    0,  1, 0, 0, 4,  0, 0,     0, 0);     // issue-order check
        vec[15] = mk(0, 0, 1, 0, 0, 0,    0,  0, 1, 0, 0,  0, 0,     0, 0);
        vec[16] = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 0,  1, 'hA4,  0, 0);
        vec[17] = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 0,  0, 0,     1, 'hA0);
        vec[18] = mk(1, 2, 0, 0, 0, 0,    0,  1, 0, 0, 2,  0, 0,     0, 0);     // leaves last grant = IF
        vec[19] = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 2,  0, 0,     0, 0);
        vec[20] = mk(0, 0, 0, 0, 0, 0,    0,  0, 0, 0, 2,  1, 'hA2,  0, 0);

        idle_inputs();
        rst_in = 1'b0;

        // Reset: everything quiet even with all requesters asserting valid.
        boot_valid_in = 1'b1;
        if_valid_in   = 1'b1;
        ls_valid_in   = 1'b1;
        @(negedge clk_in);
        chk("rst_boot_ready", 32'(boot_ready_out), 0);
        chk("rst_if_ready",   32'(if_ready_out),   0);
        chk("rst_ls_ready",   32'(ls_ready_out),   0);
        chk("rst_ram_we",     32'(ram_we_out),     0);
        chk("rst_run",        32'(run_out),        0);
        chk("rst_rvalids",    32'({if_rvalid_out, ls_rvalid_out}), 0);
        $display("reset: boot_rdy=%0b run=%0b we=%0b", boot_ready_out, run_out, ram_we_out);
        @(posedge clk_in); #1;
        rst_in      = 1'b1;
        ls_valid_in = 1'b0;

        // Boot load with IF knocking the whole time.
        for (int k = 0; k < 5; k++) begin
            boot_valid_in = 1'b1;
            boot_data_in  = 32'hA0 + 32'(k);
            if_valid_in   = 1'b1;
            if_addr_in    = 12'd3;
            @(negedge clk_in);
            chk("boot_ready", 32'(boot_ready_out), 1);
            chk("boot_we",    32'(ram_we_out),     1);
            chk("boot_addr",  32'(ram_addr_out),   32'(k));
            chk("boot_din",   ram_din_out,         32'hA0 + 32'(k));
            chk("boot_if_rdy", 32'(if_ready_out),  0);
            chk("boot_run_lo", 32'(run_out),       0);
            $display("boot %0d: addr=%0h din=%0h we=%0b", k, ram_addr_out, ram_din_out, ram_we_out);
            @(posedge clk_in); #1;
        end
        chk("run_after_boot", 32'(run_out), 1);
        idle_inputs();
        @(negedge clk_in);
        chk("run_boot_ready", 32'(boot_ready_out), 0);
        chk("run_idle_we",    32'(ram_we_out),     0);
        @(posedge clk_in); #1;

        // Table-driven run-mode vectors.
        for (int i = 0; i < NV; i++) begin
            if_valid_in = vec[i].if_v;
            if_addr_in  = vec[i].if_a;
            ls_valid_in = vec[i].ls_v;
            ls_we_in    = vec[i].ls_we;
            ls_addr_in  = vec[i].ls_a;
            ls_wdata_in = vec[i].ls_wd;
            flush_in    = vec[i].flush;
            @(negedge clk_in);
            chk($sformatf("v%0d_if_ready", i),  32'(if_ready_out),  32'(vec[i].e_if_rdy));
            chk($sformatf("v%0d_ls_ready", i),  32'(ls_ready_out),  32'(vec[i].e_ls_rdy));
            chk($sformatf("v%0d_we", i),        32'(ram_we_out),    32'(vec[i].e_we));
            chk($sformatf("v%0d_addr", i),      32'(ram_addr_out),  32'(vec[i].e_addr));
            chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid_out), 32'(vec[i].e_if_rv));
            chk($sformatf("v%0d_ls_rvalid", i), 32'(ls_rvalid_out), 32'(vec[i].e_ls_rv));
            if (vec[i].e_if_rv) chk($sformatf("v%0d_if_rdata", i), if_rdata_out, vec[i].e_if_rd);
            if (vec[i].e_ls_rv) chk($sformatf("v%0d_ls_rdata", i), ls_rdata_out, vec[i].e_ls_rd);
            if (vec[i].e_we)    chk($sformatf("v%0d_din", i),      ram_din_out,  vec[i].ls_wd);
            $display("vec %0d: if_rdy=%0b ls_rdy=%0b we=%0b addr=%0h if_rv=%0b ls_rv=%0b",
                     i, if_ready_out, ls_ready_out, ram_we_out, ram_addr_out,
                     if_rvalid_out, ls_rvalid_out);
            @(posedge clk_in); #1;
        end

        // IF and LS both requesting every cycle.
        for (int i = 0; i < 10; i++) begin
            logic exp_if;
`ifdef ARB_ROUND_ROBIN_EN
            exp_if = (i % 2) == 1;
`else
            exp_if = (i % 5) == 4;
`endif
            if_valid_in = 1'b1;
            if_addr_in  = 12'd1;
            ls_valid_in = 1'b1;
            ls_we_in    = 1'b0;
            ls_addr_in  = 12'd0;
            flush_in    = 1'b0;
            @(negedge clk_in);
            chk($sformatf("arb%0d_if_ready", i), 32'(if_ready_out), 32'(exp_if));
            chk($sformatf("arb%0d_ls_ready", i), 32'(ls_ready_out), 32'(!exp_if));
            $display("arb %0d: if_rdy=%0b ls_rdy=%0b", i, if_ready_out, ls_ready_out);
            @(posedge clk_in); #1;
        end
        idle_inputs();
        repeat (3) @(posedge clk_in);
        #1;

        // Reset asserted while an IF and an LS read are in flight.
        if_valid_in = 1'b1;
        if_addr_in  = 12'd3;
        @(posedge clk_in); #1;
        if_valid_in = 1'b0;
        ls_valid_in = 1'b1;
        ls_we_in    = 1'b0;
        ls_addr_in  = 12'd4;
        @(posedge clk_in); #1;
        ls_valid_in = 1'b0;
        #1;
        chk("inflight_if_rvalid", 32'(if_rvalid_out), 1);
        chk("inflight_if_rdata",  if_rdata_out,       32'hA3);
        rst_in = 1'b0;
        #1;
        chk("async_rst_if_rvalid", 32'(if_rvalid_out), 0);
        chk("async_rst_ls_rvalid", 32'(ls_rvalid_out), 0);
        chk("async_rst_run",       32'(run_out),       0);
        $display("async reset: if_rv=%0b ls_rv=%0b run=%0b", if_rvalid_out, ls_rvalid_out, run_out);
        @(negedge clk_in);
        chk("held_rst_ls_rvalid",  32'(ls_rvalid_out),  0);
        chk("held_rst_boot_ready", 32'(boot_ready_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
